// File: rtl/snoop_pkg.sv
// Shared types for the snoop broadcast block: AC protection/snoop fields, the CR response
// bundle with named bit positions, the broadcast FSM encoding and an index-width helper.
// No logic, no ports.
package snoop_pkg;

    typedef logic [2:0] acprot_t;
    typedef logic [3:0] acsnoop_t;
    typedef logic [4:0] resp_t;

    // Bit positions inside resp_t.
    typedef enum int unsigned {
        DataTransfer = 0,
        Error        = 1,
        PassDirty    = 2,
        IsShared     = 3,
        WasUnique    = 4
    } resp_bit_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AC,
        ST_CR,
        ST_RSP,
        ST_DATA
    } state_e;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 returns the index of the lowest set bit,
// MODE=1 the number of zeros above the highest set bit. Purely combinational.
// Ports: in_i vector, cnt_o count, empty_o high when in_i has no set bit.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        // Last match wins: walking the index down finds the lowest bit,
        // walking it up finds the highest bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (!MODE && in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            if (MODE && in_i[i])          cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/snoop_cd_mux.sv
// Routes CD data from the selected snooped port upstream and drains every other port that
// still owes data. Combinational, zero latency; the selected port sees upstream ready,
// drained ports see ready=1. Ports: en_i/sel_i/dpend_i control, mst_cd_* per port, slv_cd_* upstream.
module snoop_cd_mux
    import snoop_pkg::*;
#(
    parameter int unsigned NoPorts   = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned SelWidth  = idx_width(NoPorts)
) (
    input  logic                              en_i,
    input  logic [SelWidth-1:0]               sel_i,
    input  logic [NoPorts-1:0]                dpend_i,
    input  logic [NoPorts-1:0][DataWidth-1:0] mst_cd_data_i,
    input  logic [NoPorts-1:0]                mst_cd_last_i,
    input  logic [NoPorts-1:0]                mst_cd_valid_i,
    output logic [NoPorts-1:0]                mst_cd_ready_o,
    output logic [DataWidth-1:0]              slv_cd_data_o,
    output logic                              slv_cd_last_o,
    output logic                              slv_cd_valid_o,
    input  logic                              slv_cd_ready_i
);

    always_comb begin
        slv_cd_data_o  = '0;
        slv_cd_last_o  = 1'b0;
        slv_cd_valid_o = 1'b0;
        mst_cd_ready_o = '0;
        if (en_i) begin
            for (int i = 0; i < NoPorts; i++) begin
                // A port whose last beat has gone is no longer listened to,
                // including the selected one once its burst is complete.
                if (dpend_i[i]) begin
                    if (SelWidth'(i) == sel_i) begin
                        slv_cd_data_o     = mst_cd_data_i[i];
                        slv_cd_last_o     = mst_cd_last_i[i];
                        slv_cd_valid_o    = mst_cd_valid_i[i];
                        mst_cd_ready_o[i] = slv_cd_ready_i;
                    end else begin
                        mst_cd_ready_o[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/snoop_broadcast.sv
// Fans one upstream AC snoop out to NoPorts masters, OR-merges their CRs into one upstream CR
// and forwards CD from the lowest-index data-returning port (others drained). AC out 1 cycle
// after upstream handshake; one snoop in flight, upstream AC held off until back in IDLE.
// Ports: slv_ac/cr/cd_* upstream channels, mst_ac/cr/cd_* per-master channels, clk_i, rst_i.
module snoop_broadcast
    import snoop_pkg::*;
#(
    parameter int unsigned NoPorts   = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [AddrWidth-1:0]              slv_ac_addr_i,
    input  acprot_t                           slv_ac_prot_i,
    input  acsnoop_t                          slv_ac_snoop_i,
    input  logic [NoPorts-1:0]                slv_ac_mask_i,
    input  logic                              slv_ac_valid_i,
    output logic                              slv_ac_ready_o,
    output resp_t                             slv_cr_resp_o,
    output logic                              slv_cr_valid_o,
    input  logic                              slv_cr_ready_i,
    output logic [DataWidth-1:0]              slv_cd_data_o,
    output logic                              slv_cd_last_o,
    output logic                              slv_cd_valid_o,
    input  logic                              slv_cd_ready_i,
    output logic [NoPorts-1:0][AddrWidth-1:0] mst_ac_addr_o,
    output acprot_t  [NoPorts-1:0]            mst_ac_prot_o,
    output acsnoop_t [NoPorts-1:0]            mst_ac_snoop_o,
    output logic [NoPorts-1:0]                mst_ac_valid_o,
    input  logic [NoPorts-1:0]                mst_ac_ready_i,
    input  resp_t    [NoPorts-1:0]            mst_cr_resp_i,
    input  logic [NoPorts-1:0]                mst_cr_valid_i,
    output logic [NoPorts-1:0]                mst_cr_ready_o,
    input  logic [NoPorts-1:0][DataWidth-1:0] mst_cd_data_i,
    input  logic [NoPorts-1:0]                mst_cd_last_i,
    input  logic [NoPorts-1:0]                mst_cd_valid_i,
    output logic [NoPorts-1:0]                mst_cd_ready_o
);

    localparam int unsigned SelWidth = idx_width(NoPorts);

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    acprot_t               prot_q, prot_d;
    acsnoop_t              snoop_q, snoop_d;
    logic [NoPorts-1:0]    pend_q, pend_d;
    logic [NoPorts-1:0]    crpend_q, crpend_d;
    logic [NoPorts-1:0]    dpend_q, dpend_d;
    resp_t                 acc_q, acc_d;
    logic [SelWidth-1:0]   sel_q, sel_d;

    logic [NoPorts-1:0]    cr_hs;
    logic [NoPorts-1:0]    cd_done;
    logic [SelWidth-1:0]   dpend_low;
    logic                  dpend_none;

    assign cr_hs   = mst_cr_ready_o & mst_cr_valid_i;
    assign cd_done = mst_cd_valid_i & mst_cd_ready_o & mst_cd_last_i;

    // dpend_q is final once the FSM is in RSP, so the data source is picked from it there.
    lzc #(
        .WIDTH     (NoPorts),
        .MODE      (1'b0),
        .CNT_WIDTH (SelWidth)
    ) i_sel_lzc (
        .in_i    (dpend_q),
        .cnt_o   (dpend_low),
        .empty_o (dpend_none)
    );

    // State register and latched transaction context.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            prot_q   <= '0;
            snoop_q  <= '0;
            pend_q   <= '0;
            crpend_q <= '0;
            dpend_q  <= '0;
            acc_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            prot_q   <= prot_d;
            snoop_q  <= snoop_d;
            pend_q   <= pend_d;
            crpend_q <= crpend_d;
            dpend_q  <= dpend_d;
            acc_q    <= acc_d;
            sel_q    <= sel_d;
        end
    end

    // Next-state and context updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        prot_d   = prot_q;
        snoop_d  = snoop_q;
        pend_d   = pend_q;
        crpend_d = crpend_q;
        dpend_d  = dpend_q;
        acc_d    = acc_q;
        sel_d    = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (slv_ac_valid_i) begin
                    addr_d   = slv_ac_addr_i;
                    prot_d   = slv_ac_prot_i;
                    snoop_d  = slv_ac_snoop_i;
                    pend_d   = ~slv_ac_mask_i;
                    crpend_d = ~slv_ac_mask_i;
                    dpend_d  = '0;
                    acc_d    = '0;
                    state_d  = ST_AC;
                end
            end
            ST_AC: begin
                pend_d = pend_q & ~mst_ac_ready_i;
                // Entering AC with nothing pending only happens for a fully masked
                // snoop; it answers with the cleared merge straight away.
                if (pend_q == '0) begin
                    state_d = ST_RSP;
                end else if (pend_d == '0) begin
                    state_d = ST_CR;
                end
            end
            ST_CR: begin
                for (int i = 0; i < NoPorts; i++) begin
                    if (cr_hs[i]) begin
                        acc_d = acc_d | mst_cr_resp_i[i];
                        if (mst_cr_resp_i[i][DataTransfer]) dpend_d[i] = 1'b1;
                    end
                end
                crpend_d = crpend_q & ~cr_hs;
                if (crpend_d == '0) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (slv_cr_ready_i) begin
                    sel_d   = dpend_low;
                    state_d = dpend_none ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                dpend_d = dpend_q & ~cd_done;
                if (dpend_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        // Held low while reset is asserted even though the register already reads IDLE.
        slv_ac_ready_o = (state_q == ST_IDLE) && !rst_i;
        slv_cr_valid_o = 1'b0;
        slv_cr_resp_o  = '0;
        mst_ac_valid_o = '0;
        mst_cr_ready_o = '0;
        for (int i = 0; i < NoPorts; i++) begin
            mst_ac_addr_o[i]  = addr_q;
            mst_ac_prot_o[i]  = prot_q;
            mst_ac_snoop_o[i] = snoop_q;
        end
        case (state_q)
            ST_AC:  mst_ac_valid_o = pend_q;
            ST_CR:  mst_cr_ready_o = crpend_q;
            ST_RSP: begin
                slv_cr_valid_o = 1'b1;
                slv_cr_resp_o  = acc_q;
            end
            default: ;
        endcase
    end

    snoop_cd_mux #(
        .NoPorts   (NoPorts),
        .DataWidth (DataWidth),
        .SelWidth  (SelWidth)
    ) i_cd_mux (
        .en_i           (state_q == ST_DATA),
        .sel_i          (sel_q),
        .dpend_i        (dpend_q),
        .mst_cd_data_i  (mst_cd_data_i),
        .mst_cd_last_i  (mst_cd_last_i),
        .mst_cd_valid_i (mst_cd_valid_i),
        .mst_cd_ready_o (mst_cd_ready_o),
        .slv_cd_data_o  (slv_cd_data_o),
        .slv_cd_last_o  (slv_cd_last_o),
        .slv_cd_valid_o (slv_cd_valid_o),
        .slv_cd_ready_i (slv_cd_ready_i)
    );

endmodule

// File: tb/tb_snoop_broadcast.sv
// Directed bench for snoop_broadcast: a 4-port instance for the broadcast, data and reset
// scenarios and a 2-port instance for the single-port masked snoop.
module tb_snoop_broadcast;
    import snoop_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-port instance
    logic [AW-1:0]          ac_addr;
    acprot_t                ac_prot;
    acsnoop_t               ac_snoop;
    logic [3:0]             ac_mask;
    logic                   ac_valid, ac_ready;
    resp_t                  cr_resp;
    logic                   cr_valid, cr_ready;
    logic [DW-1:0]          cd_data;
    logic                   cd_last, cd_valid, cd_ready;
    logic [3:0][AW-1:0]     m_ac_addr;
    acprot_t  [3:0]         m_ac_prot;
    acsnoop_t [3:0]         m_ac_snoop;
    logic [3:0]             m_ac_valid, m_ac_ready;
    resp_t    [3:0]         m_cr_resp;
    logic [3:0]             m_cr_valid, m_cr_ready;
    logic [3:0][DW-1:0]     m_cd_data;
    logic [3:0]             m_cd_last, m_cd_valid, m_cd_ready;

    // 2-port instance
    logic [AW-1:0]          b_ac_addr;
    acprot_t                b_ac_prot;
    acsnoop_t               b_ac_snoop;
    logic [1:0]             b_ac_mask;
    logic                   b_ac_valid, b_ac_ready;
    resp_t                  b_cr_resp;
    logic                   b_cr_valid, b_cr_ready;
    logic [DW-1:0]          b_cd_data;
    logic                   b_cd_last, b_cd_valid, b_cd_ready;
    logic [1:0][AW-1:0]     b_m_ac_addr;
    acprot_t  [1:0]         b_m_ac_prot;
    acsnoop_t [1:0]         b_m_ac_snoop;
    logic [1:0]             b_m_ac_valid, b_m_ac_ready;
    resp_t    [1:0]         b_m_cr_resp;
    logic [1:0]             b_m_cr_valid, b_m_cr_ready;
    logic [1:0][DW-1:0]     b_m_cd_data;
    logic [1:0]             b_m_cd_last, b_m_cd_valid, b_m_cd_ready;

    snoop_broadcast #(.NoPorts(4), .AddrWidth(AW), .DataWidth(DW)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .slv_ac_addr_i(ac_addr), .slv_ac_prot_i(ac_prot), .slv_ac_snoop_i(ac_snoop),
        .slv_ac_mask_i(ac_mask), .slv_ac_valid_i(ac_valid), .slv_ac_ready_o(ac_ready),
        .slv_cr_resp_o(cr_resp), .slv_cr_valid_o(cr_valid), .slv_cr_ready_i(cr_ready),
        .slv_cd_data_o(cd_data), .slv_cd_last_o(cd_last), .slv_cd_valid_o(cd_valid),
        .slv_cd_ready_i(cd_ready),
        .mst_ac_addr_o(m_ac_addr), .mst_ac_prot_o(m_ac_prot), .mst_ac_snoop_o(m_ac_snoop),
        .mst_ac_valid_o(m_ac_valid), .mst_ac_ready_i(m_ac_ready),
        .mst_cr_resp_i(m_cr_resp), .mst_cr_valid_i(m_cr_valid), .mst_cr_ready_o(m_cr_ready),
        .mst_cd_data_i(m_cd_data), .mst_cd_last_i(m_cd_last), .mst_cd_valid_i(m_cd_valid),
        .mst_cd_ready_o(m_cd_ready)
    );

    snoop_broadcast #(.NoPorts(2), .AddrWidth(AW), .DataWidth(DW)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .slv_ac_addr_i(b_ac_addr), .slv_ac_prot_i(b_ac_prot), .slv_ac_snoop_i(b_ac_snoop),
        .slv_ac_mask_i(b_ac_mask), .slv_ac_valid_i(b_ac_valid), .slv_ac_ready_o(b_ac_ready),
        .slv_cr_resp_o(b_cr_resp), .slv_cr_valid_o(b_cr_valid), .slv_cr_ready_i(b_cr_ready),
        .slv_cd_data_o(b_cd_data), .slv_cd_last_o(b_cd_last), .slv_cd_valid_o(b_cd_valid),
        .slv_cd_ready_i(b_cd_ready),
        .mst_ac_addr_o(b_m_ac_addr), .mst_ac_prot_o(b_m_ac_prot), .mst_ac_snoop_o(b_m_ac_snoop),
        .mst_ac_valid_o(b_m_ac_valid), .mst_ac_ready_i(b_m_ac_ready),
        .mst_cr_resp_i(b_m_cr_resp), .mst_cr_valid_i(b_m_cr_valid), .mst_cr_ready_o(b_m_cr_ready),
        .mst_cd_data_i(b_m_cd_data), .mst_cd_last_i(b_m_cd_last), .mst_cd_valid_i(b_m_cd_valid),
        .mst_cd_ready_o(b_m_cd_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin : main
        int         i1, i3, cyc;
        logic [3:0] exp_rdy;

        ac_addr = '0; ac_prot = '0; ac_snoop = '0; ac_mask = '0; ac_valid = 1'b0;
        cr_ready = 1'b0; cd_ready = 1'b0;
        m_ac_ready = '0; m_cr_resp = '0; m_cr_valid = '0;
        m_cd_data = '0; m_cd_last = '0; m_cd_valid = '0;
        b_ac_addr = '0; b_ac_prot = '0; b_ac_snoop = '0; b_ac_mask = '0; b_ac_valid = 1'b0;
        b_cr_ready = 1'b0; b_cd_ready = 1'b0;
        b_m_ac_ready = '0; b_m_cr_resp = '0; b_m_cr_valid = '0;
        b_m_cd_data = '0; b_m_cd_last = '0; b_m_cd_valid = '0;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_ac_ready", ac_ready, 0);
        chk("rst_cr_valid", cr_valid, 0);
        chk("rst_cd_valid", cd_valid, 0);
        chk("rst_cd_data", cd_data, 0);
        chk("rst_m_ac_valid", m_ac_valid, 0);
        chk("rst_m_ac_addr", m_ac_addr[0], 0);
        chk("rst_m_cr_ready", m_cr_ready, 0);
        chk("rst_m_cd_ready", m_cd_ready, 0);
        chk("rst_b_ac_ready", b_ac_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_ac_ready", ac_ready, 1);
        chk("idle_b_ac_ready", b_ac_ready, 1);

        // ---- 2 ports, port0 masked, ReadShared to 0x1000
        b_ac_addr = 64'h1000; b_ac_snoop = 4'b0001; b_ac_mask = 2'b01; b_ac_valid = 1'b1;
        @(negedge clk);
        b_ac_valid = 1'b0;
        chk("t1_m_ac_valid", b_m_ac_valid, 2'b10);
        chk("t1_m_ac_addr", b_m_ac_addr[1], 64'h1000);
        chk("t1_m_ac_snoop", b_m_ac_snoop[1], 4'b0001);
        chk("t1_ac_busy", b_ac_ready, 0);
        b_m_ac_ready = 2'b10;
        @(negedge clk);
        b_m_ac_ready = 2'b00;
        chk("t1_m_cr_ready", b_m_cr_ready, 2'b10);
        b_m_cr_resp[1] = 5'b01000; b_m_cr_valid = 2'b10;
        @(negedge clk);
        b_m_cr_valid = 2'b00;
        chk("t1_cr_valid", b_cr_valid, 1);
        chk("t1_cr_resp", b_cr_resp, 5'b01000);
        b_cr_ready = 1'b1;
        @(negedge clk);
        b_cr_ready = 1'b0;
        chk("t1_back_idle", b_ac_ready, 1);
        chk("t1_no_cd", b_cd_valid, 0);
        chk("t1_no_cd_ready", b_m_cd_ready, 0);

        // ---- 4 ports, no mask, port2 slow on AC
        ac_addr = 64'h2000_0040; ac_prot = 3'b010; ac_snoop = 4'b0111; ac_mask = 4'b0000;
        ac_valid = 1'b1;
        @(negedge clk);
        ac_valid = 1'b0;
        chk("t2_ac_latency", m_ac_valid, 4'b1111);
        m_ac_ready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_ac_wait", m_ac_valid, 4'b0100);
            chk("t2_addr_stable", m_ac_addr[2], 64'h2000_0040);
            chk("t2_prot_stable", m_ac_prot[2], 3'b010);
            chk("t2_no_cr_yet", cr_valid, 0);
            m_ac_ready = (k == 2) ? 4'b0100 : 4'b0000;
        end
        @(negedge clk);
        m_ac_ready = 4'b0000;
        chk("t2_m_cr_ready", m_cr_ready, 4'b1111);
        m_cr_resp[0] = 5'b01000; m_cr_resp[1] = 5'b00101;
        m_cr_resp[2] = 5'b00000; m_cr_resp[3] = 5'b01001;
        m_cr_valid = 4'b1111;
        @(negedge clk);
        m_cr_valid = 4'b0000;
        chk("t2_cr_valid", cr_valid, 1);
        chk("t2_cr_merge", cr_resp, 5'b01101);
        chk("t2_cr_all_taken", m_cr_ready, 0);
        @(negedge clk);
        chk("t2_cr_hold_valid", cr_valid, 1);
        chk("t2_cr_hold_resp", cr_resp, 5'b01101);
        cr_ready = 1'b1;
        @(negedge clk);
        cr_ready = 1'b0;
        chk("t2_cr_done", cr_valid, 0);

        // ---- data: port1 forwarded, port3 drained (starts late), upstream ready toggling
        i1 = 0; i3 = 0; cyc = 0;
        while ((i1 < 4 || i3 < 4) && cyc < 40) begin
            m_cd_valid[1] = (i1 < 4);
            m_cd_data[1]  = 64'hA0 + 64'(i1);
            m_cd_last[1]  = (i1 == 3);
            m_cd_valid[3] = (i3 < 4) && (cyc >= 5);
            m_cd_data[3]  = 64'hB0 + 64'(i3);
            m_cd_last[3]  = (i3 == 3);
            cd_ready      = ((cyc % 2) == 0);
            #1;
            chk("t3_cd_valid", cd_valid, (i1 < 4));
            if (i1 < 4) begin
                chk("t3_cd_data", cd_data, 64'hA0 + 64'(i1));
                chk("t3_cd_last", cd_last, (i1 == 3));
            end
            exp_rdy = {(i3 < 4), 1'b0, ((i1 < 4) && cd_ready), 1'b0};
            chk("t3_m_cd_ready", m_cd_ready, exp_rdy);
            chk("t3_ac_blocked", ac_ready, 0);
            if (m_cd_valid[1] && cd_ready) i1++;
            if (m_cd_valid[3]) i3++;
            cyc++;
            @(negedge clk);
        end
        chk("t3_bounded", (cyc < 40), 1);
        m_cd_valid = '0; m_cd_last = '0; cd_ready = 1'b0;
        #1;
        chk("t3_idle", ac_ready, 1);
        chk("t3_cd_quiet", cd_valid, 0);
        chk("t3_cd_ready_quiet", m_cd_ready, 0);

        // ---- fully masked snoop
        ac_addr = 64'h3000; ac_mask = 4'b1111; ac_valid = 1'b1;
        chk("t4_ac_ready", ac_ready, 1);
        @(negedge clk);
        ac_valid = 1'b0;
        chk("t4_cr_not_yet", cr_valid, 0);
        chk("t4_no_m_ac", m_ac_valid, 0);
        @(negedge clk);
        chk("t4_cr_valid", cr_valid, 1);
        chk("t4_cr_resp", cr_resp, 5'b00000);
        chk("t4_ac_busy", ac_ready, 0);
        cr_ready = 1'b1;
        @(negedge clk);
        cr_ready = 1'b0;
        chk("t4_idle", ac_ready, 1);
        chk("t4_no_cd", cd_valid, 0);
        chk("t4_cr_gone", cr_valid, 0);

        // ---- reset mid-burst, then a normal snoop
        ac_addr = 64'h4000; ac_mask = 4'b1110; ac_valid = 1'b1;
        @(negedge clk);
        ac_valid = 1'b0;
        chk("t5_m_ac_valid", m_ac_valid, 4'b0001);
        m_ac_ready = 4'b0001;
        @(negedge clk);
        m_ac_ready = 4'b0000;
        chk("t5_m_cr_ready", m_cr_ready, 4'b0001);
        m_cr_resp[0] = 5'b00001; m_cr_valid = 4'b0001;
        @(negedge clk);
        m_cr_valid = 4'b0000;
        chk("t5_cr_resp", cr_resp, 5'b00001);
        cr_ready = 1'b1;
        @(negedge clk);
        cr_ready = 1'b0;
        m_cd_valid[0] = 1'b1; m_cd_data[0] = 64'hC0; m_cd_last[0] = 1'b0; cd_ready = 1'b1;
        #1;
        chk("t5_cd_valid", cd_valid, 1);
        chk("t5_cd_data", cd_data, 64'hC0);
        @(negedge clk);
        m_cd_data[0] = 64'hC1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ac_ready", ac_ready, 0);
        chk("t5_rst_cr_valid", cr_valid, 0);
        chk("t5_rst_cd_valid", cd_valid, 0);
        chk("t5_rst_cd_data", cd_data, 0);
        chk("t5_rst_m_ac_valid", m_ac_valid, 0);
        chk("t5_rst_m_cr_ready", m_cr_ready, 0);
        chk("t5_rst_m_cd_ready", m_cd_ready, 0);
        rst = 1'b0;
        m_cd_valid = '0; cd_ready = 1'b0;
        #1;
        chk("t5_post_rst_ready", ac_ready, 1);

        ac_addr = 64'h5000; ac_mask = 4'b0111; ac_valid = 1'b1;
        @(negedge clk);
        ac_valid = 1'b0;
        chk("t6_m_ac_valid", m_ac_valid, 4'b1000);
        chk("t6_m_ac_addr", m_ac_addr[3], 64'h5000);
        m_ac_ready = 4'b1000;
        @(negedge clk);
        m_ac_ready = 4'b0000;
        chk("t6_m_cr_ready", m_cr_ready, 4'b1000);
        m_cr_resp[3] = 5'b10000; m_cr_valid = 4'b1000;
        @(negedge clk);
        m_cr_valid = 4'b0000;
        chk("t6_cr_valid", cr_valid, 1);
        chk("t6_cr_resp", cr_resp, 5'b10000);
        cr_ready = 1'b1;
        @(negedge clk);
        cr_ready = 1'b0;
        chk("t6_idle", ac_ready, 1);
        chk("t6_no_cd", cd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
